hilo_file: RTL and testbench

- Architectural HI/LO register pair plus a 32-cycle iterative radix-2 divider that fills it.
- Sink for the single-word write enables and data produced by the HILO execute unit (MTHI/MTLO).
- Sink for 64-bit MULT/MULTU results.
- Source of the registered hi/lo words and of the 64-bit divider result bypass that the HILO unit consumes.

---
 rtl/hilo_file.sv | 174 +++++++++++++++++
 tb/tb_hilo_file.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hilo_file.sv
// HI/LO architectural register pair with a radix-2 restoring divider.
// HI/LO take MTHI/MTLO writes, multiply results, or a finished divide, in that priority order.
module hilo_file #(
  parameter int DIV_CYCLES = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        write_hi_en,
  input  logic        write_lo_en,
  input  logic [31:0] wdata,
  input  logic        mul_valid,
  input  logic [63:0] mul_result,
  input  logic        div_start,
  input  logic        div_signed,
  input  logic        div_flush,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic        div_busy,
  output logic        div_done,
  output logic [63:0] div_result,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [5:0] LAST_STEP = 6'(DIV_CYCLES - 1);

  state_t      state;
  state_t      state_next;
  logic [31:0] rem;
  logic [31:0] quo;
  logic [31:0] dvs;
  logic [31:0] dvd_raw;
  logic        q_neg;
  logic        r_neg;
  logic        by_zero;
  logic [5:0]  count;

  logic [32:0] rem_shift;
  logic [32:0] diff;
  logic        fits;
  logic [31:0] q_final;
  logic [31:0] r_final;
  logic        div_commit;

  function automatic logic [31:0] magnitude(input logic [31:0] v, input logic sgn);
    return (sgn && v[31]) ? (~v + 32'd1) : v;
  endfunction

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; a flush wins over everything and also masks a same-cycle start
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (div_start && !div_flush) state_next = RUN;
        else                         state_next = IDLE;
      end
      RUN: begin
        if (div_flush)               state_next = IDLE;
        else if (count == LAST_STEP) state_next = DONE;
        else                         state_next = RUN;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // One restoring step: shift the next dividend bit into the partial remainder and try a subtract
  always_comb begin
    rem_shift = {rem, quo[31]};
    fits      = (rem_shift >= {1'b0, dvs});
    diff      = rem_shift - {1'b0, dvs};
  end

  // Divider datapath: operand capture on start, one iteration per RUN cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      rem     <= 32'd0;
      quo     <= 32'd0;
      dvs     <= 32'd0;
      dvd_raw <= 32'd0;
      q_neg   <= 1'b0;
      r_neg   <= 1'b0;
      by_zero <= 1'b0;
      count   <= 6'd0;
    end else begin
      case (state)
        IDLE: begin
          if (div_start && !div_flush) begin
            rem     <= 32'd0;
            quo     <= magnitude(dividend, div_signed);
            dvs     <= magnitude(divisor, div_signed);
            dvd_raw <= dividend;
            q_neg   <= div_signed & (dividend[31] ^ divisor[31]);
            r_neg   <= div_signed & dividend[31];
            by_zero <= (divisor == 32'd0);
            count   <= 6'd0;
          end else begin
            count <= count;
          end
        end
        RUN: begin
          rem   <= fits ? diff[31:0] : rem_shift[31:0];
          quo   <= {quo[30:0], fits};
          count <= count + 6'd1;
        end
        default: begin
          count <= count;
        end
      endcase
    end
  end

  // Sign fix-up; divide-by-zero bypasses it and reports the raw dividend as remainder
  always_comb begin
    if (by_zero) begin
      q_final = 32'hFFFF_FFFF;
      r_final = dvd_raw;
    end else begin
      q_final = q_neg ? (~quo + 32'd1) : quo;
      r_final = r_neg ? (~rem + 32'd1) : rem;
    end
  end

  assign div_busy   = (state != IDLE);
  assign div_done   = (state == DONE);
  assign div_result = (state == DONE) ? {r_final, q_final} : 64'd0;
  assign div_commit = (state == DONE) && !div_flush;

  // HI half: MTHI, then multiply, then divide remainder
  always_ff @(posedge clk) begin
    if (reset) begin
      hi <= 32'd0;
    end else if (write_hi_en) begin
      hi <= wdata;
    end else if (mul_valid) begin
      hi <= mul_result[63:32];
    end else if (div_commit) begin
      hi <= r_final;
    end else begin
      hi <= hi;
    end
  end

  // LO half: MTLO, then multiply, then divide quotient
  always_ff @(posedge clk) begin
    if (reset) begin
      lo <= 32'd0;
    end else if (write_lo_en) begin
      lo <= wdata;
    end else if (mul_valid) begin
      lo <= mul_result[31:0];
    end else if (div_commit) begin
      lo <= q_final;
    end else begin
      lo <= lo;
    end
  end

endmodule

// File: tb/tb_hilo_file.sv
// Self-checking bench for hilo_file: table-driven HI/LO write vectors, divide table
// with a scoreboard queue, and hand-written flush / restart / reset sequences.
module tb_hilo_file;

  logic        clk = 1'b0;
  logic        reset;
  logic        write_hi_en;
  logic        write_lo_en;
  logic [31:0] wdata;
  logic        mul_valid;
  logic [63:0] mul_result;
  logic        div_start;
  logic        div_signed;
  logic        div_flush;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        div_busy;
  logic        div_done;
  logic [63:0] div_result;
  logic [31:0] hi;
  logic [31:0] lo;

  int errors = 0;
  int checks = 0;

  logic [31:0] exp_hi;
  logic [31:0] exp_lo;
  logic [63:0] sb_q[$];

  hilo_file dut (
    .clk        (clk),
    .reset      (reset),
    .write_hi_en(write_hi_en),
    .write_lo_en(write_lo_en),
    .wdata      (wdata),
    .mul_valid  (mul_valid),
    .mul_result (mul_result),
    .div_start  (div_start),
    .div_signed (div_signed),
    .div_flush  (div_flush),
    .dividend   (dividend),
    .divisor    (divisor),
    .div_busy   (div_busy),
    .div_done   (div_done),
    .div_result (div_result),
    .hi         (hi),
    .lo         (lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        hi_en;
    logic        lo_en;
    logic [31:0] wd;
    logic        mv;
    logic [63:0] mr;
    logic [31:0] e_hi;
    logic [31:0] e_lo;
  } hl_vec_t;

  typedef struct {
    logic        sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [31:0] r;
  } div_vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one divide; optionally pokes a second div_start mid-RUN that must be ignored.
  task automatic do_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] q, input logic [31:0] r, input int poke_at);
    int n;
    logic [63:0] e;
    bit seen;
    sb_q.push_back({r, q});
    div_signed = sgn;
    dividend   = a;
    divisor    = b;
    div_start  = 1'b1;
    tick();
    div_start = 1'b0;
    check("busy_after_start", {63'd0, div_busy}, 64'd1);
    seen = 1'b0;
    n = 0;
    while (n < 40 && !seen) begin
      if (n == poke_at) begin
        div_start = 1'b1;
        dividend  = 32'd99;
        divisor   = 32'd1;
        div_signed = 1'b0;
      end
      tick();
      div_start = 1'b0;
      n++;
      if (div_done) begin
        seen = 1'b1;
      end else begin
        check("hi_hold_during_div", {32'd0, hi}, {32'd0, exp_hi});
      end
    end
    if (!seen) begin
      check("div_done_timeout", 64'd0, 64'd1);
      e = sb_q.pop_front();
    end else begin
      check("div_latency", 64'(n), 64'd32);
      check("busy_in_done", {63'd0, div_busy}, 64'd1);
      if (sb_q.size() == 0) begin
        check("unexpected_done", 64'd1, 64'd0);
      end else begin
        e = sb_q.pop_front();
        check("div_result", div_result, e);
      end
      tick();
      exp_hi = r;
      exp_lo = q;
      check("hi_after_div", {32'd0, hi}, {32'd0, r});
      check("lo_after_div", {32'd0, lo}, {32'd0, q});
      check("busy_clear", {63'd0, div_busy}, 64'd0);
      check("done_single_pulse", {63'd0, div_done}, 64'd0);
    end
  endtask

  hl_vec_t  hv[6];
  div_vec_t dv[9];

  initial begin
    hv[0] = '{1'b1, 1'b0, 32'h1234_5678, 1'b0, 64'd0,                   32'h1234_5678, 32'h0};
    hv[1] = '{1'b0, 1'b1, 32'hCAFE_BABE, 1'b0, 64'd0,                   32'h1234_5678, 32'hCAFE_BABE};
    hv[2] = '{1'b0, 1'b0, 32'h0,         1'b1, 64'h0000_0001_FFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFE};
    hv[3] = '{1'b0, 1'b1, 32'h5,         1'b1, 64'h0000_0001_FFFF_FFFE, 32'h0000_0001, 32'h5};
    hv[4] = '{1'b1, 1'b1, 32'hA5A5_A5A5, 1'b1, 64'hDEAD_BEEF_0BAD_F00D, 32'hA5A5_A5A5, 32'hA5A5_A5A5};
    hv[5] = '{1'b0, 1'b0, 32'h0,         1'b0, 64'd0,                   32'hA5A5_A5A5, 32'hA5A5_A5A5};

    dv[0] = '{1'b0, 32'd100,       32'd7,         32'd14,        32'd2};
    dv[1] = '{1'b1, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 32'hFFFF_FFFF};
    dv[2] = '{1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0};
    dv[3] = '{1'b0, 32'd5,         32'd0,         32'hFFFF_FFFF, 32'd5};
    dv[4] = '{1'b1, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1};
    dv[5] = '{1'b1, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'd3,         32'hFFFF_FFFF};
    dv[6] = '{1'b1, 32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFF, 32'hFFFF_FFFB};
    dv[7] = '{1'b0, 32'hFFFF_FFFF, 32'd1,         32'hFFFF_FFFF, 32'd0};
    dv[8] = '{1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000};

    reset = 1'b1; write_hi_en = 1'b0; write_lo_en = 1'b0; wdata = 32'd0;
    mul_valid = 1'b0; mul_result = 64'd0; div_start = 1'b0; div_signed = 1'b0;
    div_flush = 1'b0; dividend = 32'd0; divisor = 32'd0;
    exp_hi = 32'd0; exp_lo = 32'd0;
    repeat (2) tick();
    reset = 1'b0;

    check("reset_hi", {32'd0, hi}, 64'd0);
    check("reset_lo", {32'd0, lo}, 64'd0);
    check("reset_busy", {63'd0, div_busy}, 64'd0);
    check("reset_done", {63'd0, div_done}, 64'd0);
    check("reset_result", div_result, 64'd0);

    for (int i = 0; i < 6; i++) begin
      write_hi_en = hv[i].hi_en;
      write_lo_en = hv[i].lo_en;
      wdata       = hv[i].wd;
      mul_valid   = hv[i].mv;
      mul_result  = hv[i].mr;
      tick();
      write_hi_en = 1'b0; write_lo_en = 1'b0; mul_valid = 1'b0;
      check($sformatf("vec%0d_hi", i), {32'd0, hi}, {32'd0, hv[i].e_hi});
      check($sformatf("vec%0d_lo", i), {32'd0, lo}, {32'd0, hv[i].e_lo});
    end
    exp_hi = 32'hA5A5_A5A5;
    exp_lo = 32'hA5A5_A5A5;

    for (int i = 0; i < 9; i++) begin
      do_div(dv[i].sgn, dv[i].a, dv[i].b, dv[i].q, dv[i].r, -1);
    end

    for (int i = 0; i < 4; i++) begin
      logic [31:0] ra;
      logic [31:0] rb;
      ra = $urandom;
      rb = $urandom_range(65535, 1);
      do_div(1'b0, ra, rb, ra / rb, ra % rb, -1);
    end

    // Flush at RUN cycle 10: no result, no HI/LO change, busy drops next cycle.
    div_signed = 1'b0; dividend = 32'd1000; divisor = 32'd7; div_start = 1'b1;
    tick();
    div_start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("flush_no_early_done", {63'd0, div_done}, 64'd0);
    end
    div_flush = 1'b1;
    tick();
    div_flush = 1'b0;
    check("flush_busy", {63'd0, div_busy}, 64'd0);
    check("flush_done", {63'd0, div_done}, 64'd0);
    check("flush_hi", {32'd0, hi}, {32'd0, exp_hi});
    check("flush_lo", {32'd0, lo}, {32'd0, exp_lo});
    do_div(1'b0, 32'd1000, 32'd3, 32'd333, 32'd1, -1);

    // A second start during RUN must not disturb the in-flight divide.
    do_div(1'b0, 32'd50, 32'd6, 32'd8, 32'd2, 5);

    // Reset in the middle of a divide.
    div_signed = 1'b0; dividend = 32'd77; divisor = 32'd7; div_start = 1'b1;
    tick();
    div_start = 1'b0;
    repeat (20) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_hi = 32'd0;
    exp_lo = 32'd0;
    check("midreset_hi", {32'd0, hi}, 64'd0);
    check("midreset_lo", {32'd0, lo}, 64'd0);
    check("midreset_busy", {63'd0, div_busy}, 64'd0);
    check("midreset_done", {63'd0, div_done}, 64'd0);
    check("midreset_result", div_result, 64'd0);
    do_div(1'b0, 32'd9, 32'd3, 32'd3, 32'd0, -1);

    check("scoreboard_empty", 64'(sb_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
